// File: rtl/xbar_egress_port.sv
`default_nettype none
// ============================================================================
// Module  : xbar_egress_port
// Crossbar egress port: round-robin lane arbitration into a first-word-fall-
// through FIFO drained over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module xbar_egress_port #(
    parameter int WIDTH   = 320,
    parameter int NUM_IN  = 4,
    parameter int SEL_W   = 6,
    parameter int PORT_ID = 0,
    parameter int DEPTH   = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN-1:0]         in_valid,
    input  logic [NUM_IN*SEL_W-1:0]   in_sel,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    output logic [NUM_IN-1:0]         in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fill_count
);

    localparam int                  c_rr_w      = $clog2(NUM_IN);
    localparam int                  c_addr_w    = $clog2(DEPTH);
    localparam int                  c_cnt_w     = c_addr_w + 1;
    localparam logic [SEL_W-1:0]    c_port      = SEL_W'(PORT_ID);
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_rr_w:0]     c_num_in    = (c_rr_w+1)'(NUM_IN);
    localparam logic [c_rr_w-1:0]   c_last_lane = c_rr_w'(NUM_IN - 1);

    logic [NUM_IN-1:0]   w_req;
    logic [NUM_IN-1:0]   w_grant;
    logic [c_rr_w-1:0]   w_grant_idx;
    logic                w_found;
    logic [c_rr_w:0]     w_sum;
    logic [c_rr_w-1:0]   w_idx;
    logic [WIDTH-1:0]    w_push_data;
    logic                w_full;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;

    logic [c_rr_w-1:0]   r_rr_ptr;
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_fill;
    logic [WIDTH-1:0]    r_mem [DEPTH];

    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_req
            assign w_req[i] = in_valid[i] && (in_sel[i*SEL_W +: SEL_W] == c_port);
        end
    endgenerate

    // Scan lanes starting at the round-robin pointer, wrapping modulo NUM_IN.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        w_push_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_rr_w+1)'(k);
            if (w_sum >= c_num_in) begin
                w_sum = w_sum - c_num_in;
            end
            w_idx = w_sum[c_rr_w-1:0];
            if (!w_found && w_req[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_grant_idx    = w_idx;
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) begin
                w_push_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Full blocks pushes even when a pop is pending, so out_ready never reaches in_ready.
    assign w_full   = (r_fill == c_depth);
    assign w_accept = !rst && !w_full;
    assign in_ready = w_grant & {NUM_IN{w_accept}};
    assign w_push   = |in_ready;
    assign w_pop    = (r_fill != '0) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_rr_ptr        <= (w_grant_idx == c_last_lane) ? '0 : w_grant_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign out_valid  = (r_fill != '0);
    assign out_data   = r_mem[r_rd_ptr];
    assign fill_count = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_xbar_egress_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_xbar_egress_port
// Self-checking bench for xbar_egress_port against a queue-based port model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_xbar_egress_port;

    localparam int WIDTH   = 32;
    localparam int NUM_IN  = 4;
    localparam int SEL_W   = 6;
    localparam int PORT_ID = 2;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN*SEL_W-1:0]   in_sel;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic [NUM_IN-1:0]         in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic                      out_ready;
    logic [CNT_W-1:0]          fill_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: accepted words in arrival order, plus the lane that gets priority.
    logic [WIDTH-1:0] q[$];
    int               m_rr = 0;

    xbar_egress_port #(
        .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .PORT_ID(PORT_ID), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic set_lane(input int i, input bit v, input int s, input logic [WIDTH-1:0] d);
        in_valid[i]               = v;
        in_sel[i*SEL_W +: SEL_W]  = SEL_W'(s);
        in_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic clear_lanes();
        in_valid = '0;
        in_sel   = '0;
        in_data  = '0;
    endtask

    // Winner = requesting lane at the smallest cyclic distance from the priority lane.
    function automatic int model_winner();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NUM_IN;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_valid[i] && in_sel[i*SEL_W +: SEL_W] == SEL_W'(PORT_ID)) begin
                d = (i - m_rr + NUM_IN) % NUM_IN;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [NUM_IN-1:0] exp_ready();
        logic [NUM_IN-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (!rst && w >= 0 && q.size() < DEPTH) r[w] = 1'b1;
        return r;
    endfunction

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic cyc();
        int w;
        bit push;
        bit pop;
        logic [WIDTH-1:0] d;
        w    = model_winner();
        push = (exp_ready() != '0);
        pop  = !rst && (q.size() > 0) && out_ready;
        d    = (w >= 0) ? in_data[w*WIDTH +: WIDTH] : '0;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_rr = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(d);
                m_rr = (w + 1) % NUM_IN;
            end
        end
        #1;
    endtask

    task automatic drain();
        clear_lanes();
        out_ready = 1'b1;
        for (int n = 0; n < 2*DEPTH && q.size() > 0; n++) begin
            #1;
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) set_lane(i, 1'b1, PORT_ID, WIDTH'(i));
        #1;
        compared++;
        if (in_ready !== '0) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        cyc();
        cyc();
        rst = 1'b0;
        clear_lanes();
        #1;
        compared++;
        if (fill_count !== '0) begin
            mismatched++;
            $display("FAIL reset_fill: got %0d required 0", fill_count);
        end
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        compared++;
        if (out_data !== '0) begin
            mismatched++;
            $display("FAIL reset_out_data: got %h required 0", out_data);
        end
    endtask

    task automatic test_single_lane();
        clear_lanes();
        set_lane(1, 1'b1, 2, 'hA5);
        out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== 4'b0010) begin
            mismatched++;
            $display("FAIL single_ready: got %b required 0010", in_ready);
        end
        cyc();
        set_lane(1, 1'b0, 0, '0);
        #1;
        compared++;
        if (out_valid !== 1'b1 || out_data !== 'hA5) begin
            mismatched++;
            $display("FAIL single_out: got valid=%b data=%h required valid=1 data=a5", out_valid, out_data);
        end
        compared++;
        if (fill_count !== 1) begin
            mismatched++;
            $display("FAIL single_fill1: got %0d required 1", fill_count);
        end
        cyc();
        #1;
        compared++;
        if (fill_count !== 0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL single_fill0: got fill=%0d valid=%b required 0/0", fill_count, out_valid);
        end
    endtask

    task automatic test_filtering();
        bit saw0;
        bit saw2;
        int sels[4] = '{2, 7, 2, 5};
        saw0 = 1'b0;
        saw2 = 1'b0;
        clear_lanes();
        for (int i = 0; i < NUM_IN; i++) set_lane(i, 1'b1, sels[i], WIDTH'(32'h100 + i));
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            compared++;
            if (in_ready[1] !== 1'b0 || in_ready[3] !== 1'b0) begin
                mismatched++;
                $display("FAIL filter_other: got in_ready=%b required bits 1,3 zero", in_ready);
            end
            compared++;
            if (in_ready !== exp_ready()) begin
                mismatched++;
                $display("FAIL filter_ready: got %b required %b", in_ready, exp_ready());
            end
            if (q.size() > 0) begin
                compared++;
                if (out_data !== q[0]) begin
                    mismatched++;
                    $display("FAIL filter_data: got %h required %h", out_data, q[0]);
                end
            end
            if (in_ready[0]) saw0 = 1'b1;
            if (in_ready[2]) saw2 = 1'b1;
            cyc();
        end
        compared++;
        if (!(saw0 && saw2)) begin
            mismatched++;
            $display("FAIL filter_both: got lane0=%b lane2=%b granted required both", saw0, saw2);
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic [NUM_IN-1:0] e;
        clear_lanes();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < NUM_IN; i++) set_lane(i, 1'b1, PORT_ID, WIDTH'(i));
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = NUM_IN'(1) << (k % NUM_IN);
            #1;
            compared++;
            if (in_ready !== e) begin
                mismatched++;
                $display("FAIL rr_grant[%0d]: got %b required %b", k, in_ready, e);
            end
            if (k > 0) begin
                compared++;
                if (out_valid !== 1'b1 || out_data !== WIDTH'((k - 1) % NUM_IN) || fill_count !== 1) begin
                    mismatched++;
                    $display("FAIL rr_out[%0d]: got v=%b d=%0d f=%0d required v=1 d=%0d f=1",
                             k, out_valid, out_data, fill_count, (k - 1) % NUM_IN);
                end
            end
            cyc();
        end
        drain();
    endtask

    task automatic test_full_backpressure();
        logic [WIDTH-1:0] popped[$];
        clear_lanes();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b0;
        set_lane(0, 1'b1, PORT_ID, 1);
        for (int v = 1; v <= 4; v++) begin
            #1;
            compared++;
            if (in_ready !== 4'b0001) begin
                mismatched++;
                $display("FAIL full_fill_ready[%0d]: got %b required 0001", v, in_ready);
            end
            cyc();
            set_lane(0, 1'b1, PORT_ID, WIDTH'(v + 1));
        end
        #1;
        compared++;
        if (fill_count !== 4 || in_ready !== '0) begin
            mismatched++;
            $display("FAIL full_state: got fill=%0d ready=%b required 4/0000", fill_count, in_ready);
        end
        cyc();
        out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== '0 || fill_count !== 4) begin
            mismatched++;
            $display("FAIL full_pop_ready: got ready=%b fill=%0d required 0000/4", in_ready, fill_count);
        end
        popped.push_back(out_data);
        cyc();
        #1;
        compared++;
        if (fill_count !== 3 || in_ready !== 4'b0001) begin
            mismatched++;
            $display("FAIL full_after_pop: got fill=%0d ready=%b required 3/0001", fill_count, in_ready);
        end
        popped.push_back(out_data);
        cyc();
        clear_lanes();
        for (int n = 0; n < 10 && out_valid; n++) begin
            #1;
            popped.push_back(out_data);
            cyc();
        end
        compared++;
        if (popped.size() != 5) begin
            mismatched++;
            $display("FAIL full_drain_count: got %0d required 5", popped.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                compared++;
                if (popped[i] !== WIDTH'(i + 1)) begin
                    mismatched++;
                    $display("FAIL full_drain[%0d]: got %0d required %0d", i, popped[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_pointer_wrap();
        clear_lanes();
        out_ready = 1'b0;
        set_lane(0, 1'b1, PORT_ID, 100);
        #1;
        cyc();
        for (int k = 0; k < 10; k++) begin
            set_lane(0, 1'b1, PORT_ID, WIDTH'(101 + k));
            out_ready = 1'b1;
            #1;
            compared++;
            if (fill_count !== 1 || out_data !== WIDTH'(100 + k) || in_ready !== 4'b0001) begin
                mismatched++;
                $display("FAIL wrap[%0d]: got fill=%0d data=%0d ready=%b required 1/%0d/0001",
                         k, fill_count, out_data, in_ready, 100 + k);
            end
            cyc();
        end
        drain();
        #1;
        compared++;
        if (fill_count !== 0) begin
            mismatched++;
            $display("FAIL wrap_drain: got %0d required 0", fill_count);
        end
    endtask

    task automatic test_reset_mid_stream();
        clear_lanes();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            set_lane(2, 1'b1, PORT_ID, WIDTH'(32'h300 + j));
            #1;
            cyc();
        end
        clear_lanes();
        #1;
        compared++;
        if (fill_count !== 3) begin
            mismatched++;
            $display("FAIL mid_fill: got %0d required 3", fill_count);
        end
        rst = 1'b1;
        set_lane(1, 1'b1, PORT_ID, 'h11);
        set_lane(3, 1'b1, PORT_ID, 'h33);
        #1;
        compared++;
        if (in_ready !== '0) begin
            mismatched++;
            $display("FAIL mid_rst_ready: got %b required 0000", in_ready);
        end
        cyc();
        rst = 1'b0;
        #1;
        compared++;
        if (fill_count !== 0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_after_rst: got fill=%0d valid=%b required 0/0", fill_count, out_valid);
        end
        compared++;
        if (in_ready !== 4'b0010) begin
            mismatched++;
            $display("FAIL mid_grant: got %b required 0010", in_ready);
        end
        cyc();
        drain();
    endtask

    task automatic test_random();
        logic [NUM_IN-1:0] acc;
        clear_lanes();
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 49) == 0);
            out_ready = ((k / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NUM_IN; i++) begin
                if (!in_valid[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_lane(i, 1'b1, ($urandom_range(0, 1) == 1) ? PORT_ID : int'($urandom_range(0, 63)),
                                 WIDTH'($urandom));
                end else if (in_sel[i*SEL_W +: SEL_W] != SEL_W'(PORT_ID) && $urandom_range(0, 2) == 0) begin
                    set_lane(i, 1'b0, 0, '0);
                end
            end
            #1;
            compared++;
            if (in_ready !== exp_ready()) begin
                mismatched++;
                $display("FAIL rand_ready[%0d]: got %b required %b", k, in_ready, exp_ready());
            end
            compared++;
            if (fill_count !== CNT_W'(q.size()) || out_valid !== (q.size() > 0)) begin
                mismatched++;
                $display("FAIL rand_fill[%0d]: got fill=%0d valid=%b required %0d", k, fill_count, out_valid, q.size());
            end
            if (q.size() > 0) begin
                compared++;
                if (out_data !== q[0]) begin
                    mismatched++;
                    $display("FAIL rand_data[%0d]: got %h required %h", k, out_data, q[0]);
                end
            end
            acc = in_ready;
            cyc();
            for (int i = 0; i < NUM_IN; i++) begin
                if (acc[i]) set_lane(i, 1'b0, 0, '0);
            end
        end
        rst = 1'b0;
        drain();
        #1;
        compared++;
        if (fill_count !== 0) begin
            mismatched++;
            $display("FAIL rand_drain: got %0d required 0", fill_count);
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        clear_lanes();
        test_reset();
        test_single_lane();
        test_filtering();
        test_round_robin();
        test_full_backpressure();
        test_pointer_wrap();
        test_reset_mid_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
